// File: rtl/periph_regbus_pkg.sv
// Shared types and constants for the peripheral register-bus fabric.
// Contents: FSM state enum, bus widths, error read-data default, timeout
// counter width, and the default slave index map of the peripheral cluster.
package periph_regbus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned TMO_W  = 16;

  localparam logic [DATA_W-1:0] ERR_DATA_DEF = 32'hDEAD_0BAD;

  // Default slave index assignment within the peripheral cluster
  localparam int unsigned SLV_UART0 = 0;
  localparam int unsigned SLV_I2C   = 1;
  localparam int unsigned SLV_USB   = 2;
  localparam int unsigned SLV_SPI   = 3;
  localparam int unsigned SLV_UART1 = 4;

endpackage

// File: rtl/periph_regbus_tmo.sv
// Slave-ack timeout counter for the register-bus fabric.
// Ports:
//   app_clk, app_rst : clock, synchronous active-high reset
//   clr              : hold the count at zero (any cycle outside ACCESS)
//   en               : count one ACCESS cycle
//   expire_c         : combinational, high in the TMO_CYC-th counted cycle
// Only instantiated when REGBUS_TIMEOUT_EN is defined.
module periph_regbus_tmo
  import periph_regbus_pkg::*;
#(
  parameter int unsigned TMO_CYC = 255
) (
  input  logic app_clk,
  input  logic app_rst,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  logic [TMO_W-1:0] cnt;

  // Count value equals the number of ACCESS cycles already completed
  always_ff @(posedge app_clk) begin
    if (app_rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  assign expire_c = en && (cnt == TMO_W'(TMO_CYC - 1));

endmodule

// File: rtl/periph_regbus_fabric.sv
// Register-bus fabric: fans one upstream reg bus out to NSLV peripheral slaves.
// Decodes the slave from reg_addr[AW-1 -: SELW], registers the request, holds
// a one-hot chip-select until the slave acks, then returns registered read
// data with a one-cycle reg_ack (reg_err flags decode/timeout errors).
// Ports:
//   app_clk, app_rst                      : clock, synchronous active-high reset
//   reg_cs/wr/addr/wdata/be               : upstream request, held until reg_ack
//   reg_rdata/ack/err                     : registered upstream response
//   slv_cs/wr/addr/wdata/be               : registered slave request
//   slv_rdata (packed NSLV*32), slv_ack   : slave responses
// Optional: define REGBUS_TIMEOUT_EN to abort accesses after TMO_CYC cycles.
module periph_regbus_fabric
  import periph_regbus_pkg::*;
#(
  parameter int unsigned       NSLV     = 5,
  parameter int unsigned       AW       = 9,
  parameter int unsigned       SELW     = 3,
  parameter int unsigned       TMO_CYC  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic                 app_clk,
  input  logic                 app_rst,
  input  logic                 reg_cs,
  input  logic                 reg_wr,
  input  logic [AW-1:0]        reg_addr,
  input  logic [DATA_W-1:0]    reg_wdata,
  input  logic [BE_W-1:0]      reg_be,
  output logic [DATA_W-1:0]    reg_rdata,
  output logic                 reg_ack,
  output logic                 reg_err,
  output logic [NSLV-1:0]      slv_cs,
  output logic                 slv_wr,
  output logic [AW-SELW-1:0]   slv_addr,
  output logic [DATA_W-1:0]    slv_wdata,
  output logic [BE_W-1:0]      slv_be,
  input  logic [NSLV*DATA_W-1:0] slv_rdata,
  input  logic [NSLV-1:0]      slv_ack
);

  state_e              state, state_n;
  logic [NSLV-1:0]     cs_n;
  logic                wr_n, ack_n, err_n;
  logic [AW-SELW-1:0]  addr_n;
  logic [DATA_W-1:0]   wdata_n, rdata_n;
  logic [BE_W-1:0]     be_n;

  logic [SELW-1:0]     req_sel;
  logic                ack_hit;
  logic [DATA_W-1:0]   sel_rdata;
  logic                tmo_exp_c;

  assign req_sel = reg_addr[AW-1 -: SELW];

  // slv_cs is one-hot, so masking with it ignores acks from other slaves
  assign ack_hit = |(slv_ack & slv_cs);

  // AND-OR read-data mux keyed by the active chip-select
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < int'(NSLV); i++) begin
      if (slv_cs[i]) begin
        sel_rdata = sel_rdata | slv_rdata[DATA_W*i +: DATA_W];
      end
    end
  end

`ifdef REGBUS_TIMEOUT_EN
  periph_regbus_tmo #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo (
    .app_clk  (app_clk),
    .app_rst  (app_rst),
    .clr      (state != ACCESS),
    .en       (state == ACCESS),
    .expire_c (tmo_exp_c)
  );
`else
  // No timeout: ACCESS waits for the slave indefinitely
  assign tmo_exp_c = (TMO_CYC == 0) && 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    cs_n    = slv_cs;
    wr_n    = slv_wr;
    addr_n  = slv_addr;
    wdata_n = slv_wdata;
    be_n    = slv_be;
    rdata_n = reg_rdata;
    err_n   = reg_err;
    ack_n   = 1'b0;

    unique case (state)
      IDLE: begin
        if (reg_cs) begin
          wr_n    = reg_wr;
          addr_n  = reg_addr[AW-SELW-1:0];
          wdata_n = reg_wdata;
          be_n    = reg_be;
          if (32'(req_sel) < NSLV) begin
            cs_n    = NSLV'(1) << req_sel;
            state_n = ACCESS;
          end else begin
            cs_n    = '0;
            rdata_n = ERR_DATA;
            err_n   = 1'b1;
            state_n = RESP;
          end
        end
      end
      ACCESS: begin
        // A real ack takes priority over a simultaneous timeout
        if (ack_hit) begin
          cs_n    = '0;
          rdata_n = slv_wr ? '0 : sel_rdata;
          err_n   = 1'b0;
          state_n = RESP;
        end else if (tmo_exp_c) begin
          cs_n    = '0;
          rdata_n = ERR_DATA;
          err_n   = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        ack_n   = 1'b1;
        state_n = IDLE;
      end
      default: begin
        cs_n    = '0;
        state_n = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      state     <= IDLE;
      slv_cs    <= '0;
      slv_wr    <= 1'b0;
      slv_addr  <= '0;
      slv_wdata <= '0;
      slv_be    <= '0;
      reg_rdata <= '0;
      reg_err   <= 1'b0;
      reg_ack   <= 1'b0;
    end else begin
      state     <= state_n;
      slv_cs    <= cs_n;
      slv_wr    <= wr_n;
      slv_addr  <= addr_n;
      slv_wdata <= wdata_n;
      slv_be    <= be_n;
      reg_rdata <= rdata_n;
      reg_err   <= err_n;
      reg_ack   <= ack_n;
    end
  end

endmodule

// File: tb/tb_periph_regbus_fabric.sv
// Directed self-checking bench for periph_regbus_fabric (NSLV=5, AW=9,
// SELW=3, TMO_CYC=8). Timeout scenarios run only with REGBUS_TIMEOUT_EN.
module tb_periph_regbus_fabric;

  localparam int unsigned NSLV = 5;
  localparam int unsigned AW   = 9;
  localparam int unsigned SELW = 3;
  localparam logic [31:0] ERRD = 32'hDEAD_0BAD;

  logic                 app_clk = 1'b0;
  logic                 app_rst;
  logic                 reg_cs, reg_wr;
  logic [AW-1:0]        reg_addr;
  logic [31:0]          reg_wdata;
  logic [3:0]           reg_be;
  logic [31:0]          reg_rdata;
  logic                 reg_ack, reg_err;
  logic [NSLV-1:0]      slv_cs;
  logic                 slv_wr;
  logic [AW-SELW-1:0]   slv_addr;
  logic [31:0]          slv_wdata;
  logic [3:0]           slv_be;
  logic [NSLV*32-1:0]   slv_rdata;
  logic [NSLV-1:0]      slv_ack;
  logic [NSLV-1:0]      ack_man;
  logic                 ack_auto;

  int vec  = 0;
  int miss = 0;

  always #5 app_clk = ~app_clk;

  // Zero-wait slave model when ack_auto is set, otherwise directed acks
  always_comb slv_ack = ack_auto ? slv_cs : ack_man;

  periph_regbus_fabric #(
    .NSLV    (NSLV),
    .AW      (AW),
    .SELW    (SELW),
    .TMO_CYC (8)
  ) dut (
    .app_clk   (app_clk),
    .app_rst   (app_rst),
    .reg_cs    (reg_cs),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_be    (reg_be),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack),
    .reg_err   (reg_err),
    .slv_cs    (slv_cs),
    .slv_wr    (slv_wr),
    .slv_addr  (slv_addr),
    .slv_wdata (slv_wdata),
    .slv_be    (slv_be),
    .slv_rdata (slv_rdata),
    .slv_ack   (slv_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge app_clk);
    #1;
  endtask

  logic [31:0] bb_data [4];

  initial begin
    app_rst   = 1'b1;
    reg_cs    = 1'b0;
    reg_wr    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    reg_be    = '0;
    ack_man   = '0;
    ack_auto  = 1'b0;
    bb_data[0] = 32'h1111_0000;
    bb_data[1] = 32'h2222_0001;
    bb_data[2] = 32'h3333_0002;
    bb_data[3] = 32'h4444_0003;
    for (int i = 0; i < 4; i++) slv_rdata[32*i +: 32] = bb_data[i];
    slv_rdata[32*4 +: 32] = 32'h0000_00A5;

    // Reset values
    tick(); tick();
    chk("rst_cs",    32'(slv_cs), 32'h0);
    chk("rst_ack",   32'(reg_ack), 32'h0);
    chk("rst_err",   32'(reg_err), 32'h0);
    chk("rst_rdata", reg_rdata, 32'h0);
    app_rst = 1'b0;
    tick();

    // 1. Write to slave 3, ack in first cs cycle
    reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = 9'h0C4;
    reg_wdata = 32'h1234_5678; reg_be = 4'hF;
    tick();
    chk("t1_cs",    32'(slv_cs), 32'h08);
    chk("t1_addr",  32'(slv_addr), 32'h04);
    chk("t1_wdata", slv_wdata, 32'h1234_5678);
    chk("t1_wr",    32'(slv_wr), 32'h1);
    chk("t1_be",    32'(slv_be), 32'hF);
    chk("t1_ack0",  32'(reg_ack), 32'h0);
    ack_man = 5'b01000;
    tick();
    ack_man = '0;
    chk("t1_csdrop", 32'(slv_cs), 32'h0);
    chk("t1_ack1",   32'(reg_ack), 32'h0);
    tick();
    chk("t1_ack2", 32'(reg_ack), 32'h1);
    chk("t1_err",  32'(reg_err), 32'h0);
    reg_cs = 1'b0;
    tick();
    chk("t1_ackpulse", 32'(reg_ack), 32'h0);

    // 2. Read slave 4 with 3 wait cycles and a spurious ack from slave 0
    reg_cs = 1'b1; reg_wr = 1'b0; reg_addr = 9'h100; reg_be = 4'h3;
    tick();
    chk("t2_cs1",   32'(slv_cs), 32'h10);
    chk("t2_addr",  32'(slv_addr), 32'h00);
    chk("t2_wr",    32'(slv_wr), 32'h0);
    ack_man = 5'b00001;
    tick();
    ack_man = '0;
    chk("t2_cs2",   32'(slv_cs), 32'h10);
    chk("t2_spur",  32'(reg_ack), 32'h0);
    tick();
    chk("t2_cs3",   32'(slv_cs), 32'h10);
    tick();
    chk("t2_cs4",   32'(slv_cs), 32'h10);
    ack_man = 5'b10000;
    tick();
    ack_man = '0;
    chk("t2_csdrop", 32'(slv_cs), 32'h0);
    chk("t2_ack4",   32'(reg_ack), 32'h0);
    tick();
    chk("t2_ack5",  32'(reg_ack), 32'h1);
    chk("t2_rdata", reg_rdata, 32'h0000_00A5);
    chk("t2_err",   32'(reg_err), 32'h0);
    reg_cs = 1'b0;
    tick();

    // 3. Decode error, sel=7
    reg_cs = 1'b1; reg_addr = 9'h1C0;
    tick();
    chk("t3_cs",   32'(slv_cs), 32'h0);
    chk("t3_ack0", 32'(reg_ack), 32'h0);
    tick();
    chk("t3_ack1",  32'(reg_ack), 32'h1);
    chk("t3_rdata", reg_rdata, ERRD);
    chk("t3_err",   32'(reg_err), 32'h1);
    reg_cs = 1'b0;
    tick();
    chk("t3_hold", reg_rdata, ERRD);

`ifdef REGBUS_TIMEOUT_EN
    // 4a. Slave 1 never acks: cs held 8 ACCESS cycles then timeout
    reg_cs = 1'b1; reg_addr = 9'h040;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("t4a_cs", 32'(slv_cs), 32'h02);
    end
    tick();
    chk("t4a_csdrop", 32'(slv_cs), 32'h0);
    tick();
    chk("t4a_ack",   32'(reg_ack), 32'h1);
    chk("t4a_err",   32'(reg_err), 32'h1);
    chk("t4a_rdata", reg_rdata, ERRD);
    reg_cs = 1'b0;
    tick();

    // 4b. Ack lands on the expiry cycle: normal response wins
    reg_cs = 1'b1; reg_addr = 9'h040;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("t4b_cs", 32'(slv_cs), 32'h02);
    end
    ack_man = 5'b00010;
    tick();
    ack_man = '0;
    chk("t4b_csdrop", 32'(slv_cs), 32'h0);
    tick();
    chk("t4b_ack",   32'(reg_ack), 32'h1);
    chk("t4b_err",   32'(reg_err), 32'h0);
    chk("t4b_rdata", reg_rdata, bb_data[1]);
    reg_cs = 1'b0;
    tick();
`endif

    // 5. Reset while slave 2 is selected; a late ack must do nothing
    reg_cs = 1'b1; reg_addr = 9'h080;
    tick();
    chk("t5_cs", 32'(slv_cs), 32'h04);
    app_rst = 1'b1; reg_cs = 1'b0;
    tick();
    app_rst = 1'b0;
    chk("t5_csclr", 32'(slv_cs), 32'h0);
    chk("t5_ack0",  32'(reg_ack), 32'h0);
    chk("t5_rdata", reg_rdata, 32'h0);
    ack_man = 5'b00100;
    tick();
    chk("t5_ack1", 32'(reg_ack), 32'h0);
    chk("t5_cs1",  32'(slv_cs), 32'h0);
    tick();
    chk("t5_ack2", 32'(reg_ack), 32'h0);
    ack_man = '0;
    tick();

    // 6. Back-to-back reads to slaves 0..3 with zero-wait slaves
    ack_auto = 1'b1;
    reg_cs = 1'b1; reg_wr = 1'b0; reg_addr = 9'h000;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_cs",    32'(slv_cs), 32'(5'b00001 << k));
      chk("t6_ackA",  32'(reg_ack), 32'h0);
      tick();
      chk("t6_csoff", 32'(slv_cs), 32'h0);
      chk("t6_ackB",  32'(reg_ack), 32'h0);
      tick();
      chk("t6_ack",   32'(reg_ack), 32'h1);
      chk("t6_rdata", reg_rdata, bb_data[k]);
      chk("t6_err",   32'(reg_err), 32'h0);
      if (k < 3) reg_addr = 9'(64 * (k + 1));
      else reg_cs = 1'b0;
    end
    tick();
    chk("t6_idle", 32'(reg_ack), 32'h0);
    ack_auto = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
